sorted_move_queue: RTL and testbench
====================================

// Module: sorted_move_queue
// PURPOSE
//  Parametrised successor to the move-ordering sorter. It is a shift-register priority queue of
//  (key, value) pairs, kept sorted by key, with the best entry always at slot 0.
//  It adds a selectable sort direction, a valid mask (key 0 is a legal key), and push+pop in the same cycle.
//  It also adds defined overflow (the worse entry is dropped) and flush.
//  Sits between the move generator/scorer and the search FSM; the search pops the best move first.
// PARAMETERS
//  DEPTH       32  number of slots, >=2
//  KEY_BITS    8   score width, unsigned
//  VALUE_BITS  15  move-encoding width
//  DESCENDING  1   1: largest key at head; 0: smallest key at head
// PORTS
//  clk_in         in   1                     clock
//  rst_in         in   1                     async reset, active-high
//  flush_in       in   1                     empty the queue (next edge)
//  push_in        in   1                     insert push_key_in/push_value_in this cycle
//  push_key_in    in   KEY_BITS              key of the entry to insert
//  push_value_in  in   VALUE_BITS            value of the entry to insert
//  pop_in         in   1                     remove head this cycle (ignored when empty)
//  head_valid_out out  1                     count_out != 0
//  head_key_out   out  KEY_BITS              slot 0 key
//  head_value_out out  VALUE_BITS            slot 0 value
//  keys_out       out  DEPTH*KEY_BITS        all keys, slot 0 = head
//  values_out     out  DEPTH*VALUE_BITS      all values, slot 0 = head
//  count_out      out  $clog2(DEPTH+1)       number of valid entries, 0..DEPTH
//  full_out       out  1                     count_out == DEPTH
//  overflow_out   out  1                     1-cycle pulse: an entry was dropped
// BEHAVIOUR
//  Clocking and reset:
//   - Single clock domain; all state is registered.
//   - rst_in is async active-high: all slots 0, count 0, overflow_out 0, head_valid_out 0.
//   - Reset mid-operation discards everything, including a push in the same cycle.
//  Ordering:
//   - "better" means key > (DESCENDING=1) or key < (DESCENDING=0).
//   - Slot i is never worse than slot i+1.
//   - Equal keys are FIFO: a new entry lands after all existing entries with an equal key.
//  Push only, count < DEPTH:
//   - Insert position p = number of valid entries that are better than or equal to the new key.
//   - Slots >= p shift up by one; count+1.
//   - Result is visible 1 cycle after the push edge.
//  Push only, full:
//   - If the new key is strictly better than slot DEPTH-1: the tail is dropped and the new entry inserted.
//   - Otherwise the new entry is dropped.
//   - Either way count stays DEPTH and overflow_out pulses.
//  Pop only:
//   - count > 0: slots shift down, the vacated tail is zeroed, count-1.
//   - count == 0: no effect.
//  Push + pop, count > 0:
//   - Result equals pop-then-push, done in one edge; count unchanged.
//   - Never overflows, even when full.
//  Push + pop, count == 0: pop ignored, push performed.
//  Flush:
//   - Priority flush > push/pop; simultaneous push is discarded.
//   - All slots zeroed, count 0, no overflow pulse.
//  Invalid slots:
//   - Invalid slots (index >= count) always read key 0 and value 0.
//   - Invalid slots are excluded from comparisons via a mask derived from count.
//  Other rules:
//   - push_in and pop_in are always accepted; there is no ready or backpressure.
//   - Comparisons are unsigned over KEY_BITS; no arithmetic on keys.
// CONFIGURATION
//  `define SORTED_QUEUE_DROP_CNT_EN
//   - Adds output drop_count_out [15:0]: count of entries discarded by overflow.
//   - The counter saturates at 16'hFFFF, is cleared only by rst_in, and updates on the edge that pulses overflow_out.
//  Without the macro the port and counter do not exist; all other behaviour is identical.
// STRUCTURE
//  Package sorted_queue_pkg:
//   - Default widths MOVE_VALUE_BITS=15, MOVE_KEY_BITS=8, and DROP_CNT_BITS=16.
//   - typedef enum {SLOT_HOLD, SLOT_SHIFT_UP, SLOT_SHIFT_DOWN, SLOT_LOAD, SLOT_CLEAR} slot_op_e.
//  Sub-module sorted_queue_slot: one key/value register.
//   - Async reset.
//   - Takes slot_op_e, the lower neighbour, the upper neighbour and the new entry.
//   - Instantiated DEPTH times via generate.
//  Top level holds:
//   - The better-or-equal compare vector and valid mask.
//   - Per-slot op decode for push, pop and push+pop.
//   - Count, the overflow logic and the optional counter.
// TESTING
//  1. Directed scenarios, with DESCENDING=1, DEPTH=4:
//   a. Reset, then push keys 5,9,1,9(value 7),9(value 8):
//      -> keys {9,9,9,5}, and the last two 9s hold values 7,8 in that order.
//      -> overflow_out pulses on the 5th push (key 1 is dropped).
//   b. Full queue {9,7,5,3}, push 4 -> overflow_out=1, keys {9,7,5,4}, count 4.
//      Then push 2 -> overflow_out=1, unchanged.
//   c. Queue {8,6}, push 7 and pop in the same cycle -> keys {7,6}, count 2, head_key_out=7 next cycle.
//   d. Empty queue, pop -> count 0. Push key 0 + pop -> count 1, head_valid_out=1, head_key_out=0.
//   e. Full queue, flush_in with push_in -> count 0, all keys 0, no overflow.
//      Assert rst_in between edges mid-fill -> outputs 0 immediately.
//  2. With DESCENDING=0, push 3,1,2 -> keys {1,2,3,0}.
//  3. With SORTED_QUEUE_DROP_CNT_EN: 3 overflows -> drop_count_out=3. Flush does not clear it.

Source files
------------

// File: rtl/sorted_queue_pkg.sv
// Shared widths and per-slot operation codes for the sorted move queue.
package sorted_queue_pkg;

  localparam int MOVE_VALUE_BITS = 15;
  localparam int MOVE_KEY_BITS   = 8;
  localparam int DROP_CNT_BITS   = 16;

  typedef enum logic [2:0] {
    SLOT_HOLD,
    SLOT_SHIFT_UP,
    SLOT_SHIFT_DOWN,
    SLOT_LOAD,
    SLOT_CLEAR
  } slot_op_e;

endpackage

// File: rtl/sorted_queue_slot.sv
// One key/value register of the queue; the top decides which source it takes each edge.
module sorted_queue_slot
  import sorted_queue_pkg::*;
#(
  parameter int KEY_BITS   = MOVE_KEY_BITS,
  parameter int VALUE_BITS = MOVE_VALUE_BITS
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  slot_op_e              op_in,
  input  logic [KEY_BITS-1:0]   lower_key_in,
  input  logic [VALUE_BITS-1:0] lower_value_in,
  input  logic [KEY_BITS-1:0]   upper_key_in,
  input  logic [VALUE_BITS-1:0] upper_value_in,
  input  logic [KEY_BITS-1:0]   new_key_in,
  input  logic [VALUE_BITS-1:0] new_value_in,
  output logic [KEY_BITS-1:0]   key_out,
  output logic [VALUE_BITS-1:0] value_out
);

  logic [KEY_BITS-1:0]   key_q, key_d;
  logic [VALUE_BITS-1:0] value_q, value_d;

  always_comb begin
    key_d   = key_q;
    value_d = value_q;
    case (op_in)
      SLOT_SHIFT_UP: begin
        key_d   = lower_key_in;
        value_d = lower_value_in;
      end
      SLOT_SHIFT_DOWN: begin
        key_d   = upper_key_in;
        value_d = upper_value_in;
      end
      SLOT_LOAD: begin
        key_d   = new_key_in;
        value_d = new_value_in;
      end
      SLOT_CLEAR: begin
        key_d   = '0;
        value_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      key_q   <= '0;
      value_q <= '0;
    end else begin
      key_q   <= key_d;
      value_q <= value_d;
    end
  end

  assign key_out   = key_q;
  assign value_out = value_q;

endmodule

// File: rtl/sorted_move_queue.sv
// Shift-register priority queue of (key, value) pairs, best key at slot 0, FIFO among equal keys.
// Optional SORTED_QUEUE_DROP_CNT_EN adds a saturating drop_count_out of overflow discards.
module sorted_move_queue
  import sorted_queue_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int KEY_BITS   = MOVE_KEY_BITS,
  parameter int VALUE_BITS = MOVE_VALUE_BITS,
  parameter bit DESCENDING = 1'b1
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        flush_in,
  input  logic                        push_in,
  input  logic [KEY_BITS-1:0]         push_key_in,
  input  logic [VALUE_BITS-1:0]       push_value_in,
  input  logic                        pop_in,
  output logic                        head_valid_out,
  output logic [KEY_BITS-1:0]         head_key_out,
  output logic [VALUE_BITS-1:0]       head_value_out,
  output logic [DEPTH*KEY_BITS-1:0]   keys_out,
  output logic [DEPTH*VALUE_BITS-1:0] values_out,
  output logic [$clog2(DEPTH+1)-1:0]  count_out,
  output logic                        full_out,
`ifdef SORTED_QUEUE_DROP_CNT_EN
  output logic [DROP_CNT_BITS-1:0]    drop_count_out,
`endif
  output logic                        overflow_out
);

  localparam int              CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

  logic [KEY_BITS-1:0]   slot_key   [DEPTH];
  logic [VALUE_BITS-1:0] slot_value [DEPTH];
  slot_op_e              slot_op    [DEPTH];

  logic [DEPTH-1:0] valid_mask, ge_vec;
  logic [CW-1:0]    count_q, count_d, ins_pos, load_pos;
  logic             overflow_q, overflow_d;
  logic             do_pop, is_full, keep_new;

  // Sorted contents make ge_vec a prefix of ones, so its popcount is the insert slot.
  always_comb begin
    valid_mask = '0;
    ge_vec     = '0;
    ins_pos    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_mask[i] = CW'(i) < count_q;
      ge_vec[i]     = valid_mask[i] && (DESCENDING ? (slot_key[i] >= push_key_in)
                                                   : (slot_key[i] <= push_key_in));
      if (ge_vec[i]) ins_pos = ins_pos + CW'(1);
    end
  end

  always_comb begin
    do_pop     = pop_in && (count_q != '0);
    is_full    = count_q == FULL_CNT;
    keep_new   = !is_full || (ins_pos != FULL_CNT);
    // After the head leaves, everything that was ahead of the new entry sits one slot lower.
    load_pos   = (ins_pos == '0) ? '0 : ins_pos - CW'(1);
    count_d    = count_q;
    overflow_d = 1'b0;
    for (int i = 0; i < DEPTH; i++) slot_op[i] = SLOT_HOLD;

    if (flush_in) begin
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) slot_op[i] = SLOT_CLEAR;
    end else if (push_in && do_pop) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) < load_pos)       slot_op[i] = SLOT_SHIFT_DOWN;
        else if (CW'(i) == load_pos) slot_op[i] = SLOT_LOAD;
      end
    end else if (push_in) begin
      overflow_d = is_full;
      if (!is_full) count_d = count_q + CW'(1);
      if (keep_new) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == ins_pos)      slot_op[i] = SLOT_LOAD;
          else if (CW'(i) > ins_pos)  slot_op[i] = SLOT_SHIFT_UP;
        end
      end
    end else if (do_pop) begin
      count_d = count_q - CW'(1);
      for (int i = 0; i < DEPTH; i++) slot_op[i] = SLOT_SHIFT_DOWN;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef SORTED_QUEUE_DROP_CNT_EN
  logic [DROP_CNT_BITS-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (overflow_d && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_BITS'(1);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count_out = drop_cnt_q;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [KEY_BITS-1:0]   lower_key, upper_key;
    logic [VALUE_BITS-1:0] lower_value, upper_value;

    if (i == 0) begin : g_head
      assign lower_key   = '0;
      assign lower_value = '0;
    end else begin : g_body
      assign lower_key   = slot_key[i-1];
      assign lower_value = slot_value[i-1];
    end

    // The top slot pulls in zeros on a pop, which keeps vacated slots cleared.
    if (i == DEPTH - 1) begin : g_tail
      assign upper_key   = '0;
      assign upper_value = '0;
    end else begin : g_inner
      assign upper_key   = slot_key[i+1];
      assign upper_value = slot_value[i+1];
    end

    sorted_queue_slot #(
      .KEY_BITS   (KEY_BITS),
      .VALUE_BITS (VALUE_BITS)
    ) u_slot (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .op_in          (slot_op[i]),
      .lower_key_in   (lower_key),
      .lower_value_in (lower_value),
      .upper_key_in   (upper_key),
      .upper_value_in (upper_value),
      .new_key_in     (push_key_in),
      .new_value_in   (push_value_in),
      .key_out        (slot_key[i]),
      .value_out      (slot_value[i])
    );

    assign keys_out[i*KEY_BITS +: KEY_BITS]       = slot_key[i];
    assign values_out[i*VALUE_BITS +: VALUE_BITS] = slot_value[i];
  end

  assign head_valid_out = count_q != '0;
  assign head_key_out   = slot_key[0];
  assign head_value_out = slot_value[0];
  assign count_out      = count_q;
  assign full_out       = count_q == FULL_CNT;
  assign overflow_out   = overflow_q;

endmodule

// File: tb/tb_sorted_move_queue.sv
// Directed bench: a descending and an ascending DEPTH=4 queue share one stimulus stream.
module tb_sorted_move_queue;

  localparam int DEPTH = 4;
  localparam int KB    = 8;
  localparam int VB    = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush_in = 1'b0;
  logic push_in  = 1'b0;
  logic pop_in   = 1'b0;
  logic [KB-1:0] push_key_in   = '0;
  logic [VB-1:0] push_value_in = '0;

  logic              d_head_valid, a_head_valid;
  logic [KB-1:0]     d_head_key, a_head_key;
  logic [VB-1:0]     d_head_value, a_head_value;
  logic [DEPTH*KB-1:0] d_keys, a_keys;
  logic [DEPTH*VB-1:0] d_values, a_values;
  logic [2:0]        d_count, a_count;
  logic              d_full, a_full;
  logic              d_ovf, a_ovf;
`ifdef SORTED_QUEUE_DROP_CNT_EN
  logic [15:0]       d_drop, a_drop;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sorted_move_queue #(.DEPTH(DEPTH), .KEY_BITS(KB), .VALUE_BITS(VB), .DESCENDING(1'b1)) dut_desc (
    .clk_in(clk), .rst_in(rst), .flush_in(flush_in), .push_in(push_in),
    .push_key_in(push_key_in), .push_value_in(push_value_in), .pop_in(pop_in),
    .head_valid_out(d_head_valid), .head_key_out(d_head_key), .head_value_out(d_head_value),
    .keys_out(d_keys), .values_out(d_values), .count_out(d_count), .full_out(d_full),
`ifdef SORTED_QUEUE_DROP_CNT_EN
    .drop_count_out(d_drop),
`endif
    .overflow_out(d_ovf)
  );

  sorted_move_queue #(.DEPTH(DEPTH), .KEY_BITS(KB), .VALUE_BITS(VB), .DESCENDING(1'b0)) dut_asc (
    .clk_in(clk), .rst_in(rst), .flush_in(flush_in), .push_in(push_in),
    .push_key_in(push_key_in), .push_value_in(push_value_in), .pop_in(pop_in),
    .head_valid_out(a_head_valid), .head_key_out(a_head_key), .head_value_out(a_head_value),
    .keys_out(a_keys), .values_out(a_values), .count_out(a_count), .full_out(a_full),
`ifdef SORTED_QUEUE_DROP_CNT_EN
    .drop_count_out(a_drop),
`endif
    .overflow_out(a_ovf)
  );

  // Expected key vector, slot 0 in the low byte.
  function automatic logic [DEPTH*KB-1:0] pk(input logic [KB-1:0] k0, input logic [KB-1:0] k1,
                                             input logic [KB-1:0] k2, input logic [KB-1:0] k3);
    return {k3, k2, k1, k0};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
  task automatic step(input logic p, input logic [KB-1:0] k, input logic [VB-1:0] v,
                      input logic po, input logic f);
    @(negedge clk);
    push_in = p; push_key_in = k; push_value_in = v; pop_in = po; flush_in = f;
    @(posedge clk);
    #1;
    push_in = 1'b0; pop_in = 1'b0; flush_in = 1'b0;
  endtask

  task automatic push(input logic [KB-1:0] k, input logic [VB-1:0] v);
    step(1'b1, k, v, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (d_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d exp 0", d_count); end
    total++; if (d_keys !== '0) begin bad++; $display("FAIL reset_keys: got %h exp 0", d_keys); end
    total++; if (d_head_valid !== 1'b0 || d_ovf !== 1'b0 || d_full !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got hv=%b ovf=%b full=%b exp 0 0 0", d_head_valid, d_ovf, d_full);
    end
  endtask

  task automatic test_fill_equal_keys();
    apply_reset();
    push(8'd5, 15'd1);
    total++; if (d_head_key !== 8'd5 || d_head_valid !== 1'b1) begin
      bad++; $display("FAIL first_push_head: got key=%0d hv=%b exp 5 1", d_head_key, d_head_valid);
    end
    push(8'd9, 15'd2);
    push(8'd1, 15'd3);
    push(8'd9, 15'd7);
    total++; if (d_keys !== pk(9, 9, 5, 1) || d_ovf !== 1'b0 || d_full !== 1'b1) begin
      bad++; $display("FAIL fill4: got keys=%h ovf=%b full=%b exp %h 0 1", d_keys, d_ovf, d_full, pk(9, 9, 5, 1));
    end
    push(8'd9, 15'd8);
    total++; if (d_keys !== pk(9, 9, 9, 5)) begin
      bad++; $display("FAIL fill5_keys: got %h exp %h", d_keys, pk(9, 9, 9, 5));
    end
    total++; if (d_values !== {15'd1, 15'd8, 15'd7, 15'd2}) begin
      bad++; $display("FAIL fill5_fifo_values: got %h exp %h", d_values, {15'd1, 15'd8, 15'd7, 15'd2});
    end
    total++; if (d_ovf !== 1'b1 || d_count !== 3'd4) begin
      bad++; $display("FAIL fill5_ovf: got ovf=%b cnt=%0d exp 1 4", d_ovf, d_count);
    end
    step(1'b0, 8'd0, 15'd0, 1'b0, 1'b0);
    total++; if (d_ovf !== 1'b0) begin bad++; $display("FAIL ovf_pulse_width: got %b exp 0", d_ovf); end
  endtask

  task automatic test_overflow();
    apply_reset();
    push(8'd9, 15'd1); push(8'd7, 15'd2); push(8'd5, 15'd3); push(8'd3, 15'd4);
    push(8'd4, 15'd5);
    total++; if (d_keys !== pk(9, 7, 5, 4) || d_ovf !== 1'b1 || d_count !== 3'd4) begin
      bad++; $display("FAIL ovf_insert: got keys=%h ovf=%b cnt=%0d exp %h 1 4", d_keys, d_ovf, d_count, pk(9, 7, 5, 4));
    end
    push(8'd2, 15'd6);
    total++; if (d_keys !== pk(9, 7, 5, 4) || d_ovf !== 1'b1 || d_count !== 3'd4) begin
      bad++; $display("FAIL ovf_drop_new: got keys=%h ovf=%b cnt=%0d exp %h 1 4", d_keys, d_ovf, d_count, pk(9, 7, 5, 4));
    end
    total++; if (d_values[4*VB-1:3*VB] !== 15'd5) begin
      bad++; $display("FAIL ovf_tail_value: got %0d exp 5", d_values[4*VB-1:3*VB]);
    end
  endtask

  task automatic test_push_pop();
    apply_reset();
    push(8'd8, 15'd1); push(8'd6, 15'd2);
    step(1'b1, 8'd7, 15'd3, 1'b1, 1'b0);
    total++; if (d_keys !== pk(7, 6, 0, 0) || d_count !== 3'd2 || d_head_key !== 8'd7) begin
      bad++; $display("FAIL pushpop_head: got keys=%h cnt=%0d head=%0d exp %h 2 7", d_keys, d_count, d_head_key, pk(7, 6, 0, 0));
    end
    step(1'b1, 8'd2, 15'd4, 1'b1, 1'b0);
    total++; if (d_keys !== pk(6, 2, 0, 0) || d_head_value !== 15'd2) begin
      bad++; $display("FAIL pushpop_mid: got keys=%h hval=%0d exp %h 2", d_keys, d_head_value, pk(6, 2, 0, 0));
    end
    step(1'b0, 8'd0, 15'd0, 1'b1, 1'b0);
    total++; if (d_keys !== pk(2, 0, 0, 0) || d_values !== {45'd0, 15'd4} || d_count !== 3'd1) begin
      bad++; $display("FAIL pop_only: got keys=%h vals=%h cnt=%0d exp %h 1", d_keys, d_values, d_count, pk(2, 0, 0, 0));
    end
  endtask

  task automatic test_back_to_back_full();
    apply_reset();
    push(8'd1, 15'd1); push(8'd2, 15'd2); push(8'd3, 15'd3); push(8'd4, 15'd4);
    step(1'b1, 8'd0, 15'd9, 1'b1, 1'b0);
    total++; if (d_keys !== pk(3, 2, 1, 0) || d_count !== 3'd4 || d_ovf !== 1'b0) begin
      bad++; $display("FAIL full_pushpop: got keys=%h cnt=%0d ovf=%b exp %h 4 0", d_keys, d_count, d_ovf, pk(3, 2, 1, 0));
    end
  endtask

  task automatic test_empty();
    apply_reset();
    step(1'b0, 8'd0, 15'd0, 1'b1, 1'b0);
    total++; if (d_count !== 3'd0 || d_head_valid !== 1'b0) begin
      bad++; $display("FAIL empty_pop: got cnt=%0d hv=%b exp 0 0", d_count, d_head_valid);
    end
    step(1'b1, 8'd0, 15'd5, 1'b1, 1'b0);
    total++; if (d_count !== 3'd1 || d_head_valid !== 1'b1 || d_head_key !== 8'd0 || d_head_value !== 15'd5) begin
      bad++; $display("FAIL empty_pushpop: got cnt=%0d hv=%b key=%0d val=%0d exp 1 1 0 5",
                      d_count, d_head_valid, d_head_key, d_head_value);
    end
  endtask

  task automatic test_flush_and_async_reset();
    apply_reset();
    push(8'd9, 15'd1); push(8'd7, 15'd2); push(8'd5, 15'd3); push(8'd3, 15'd4);
    step(1'b1, 8'd8, 15'd5, 1'b0, 1'b1);
    total++; if (d_count !== 3'd0 || d_keys !== '0 || d_values !== '0 || d_ovf !== 1'b0) begin
      bad++; $display("FAIL flush: got cnt=%0d keys=%h vals=%h ovf=%b exp 0 0 0 0", d_count, d_keys, d_values, d_ovf);
    end
    push(8'd5, 15'd1); push(8'd6, 15'd2);
    #2;
    rst = 1'b1;
    #1;
    total++; if (d_count !== 3'd0 || d_keys !== '0 || d_head_valid !== 1'b0) begin
      bad++; $display("FAIL async_reset: got cnt=%0d keys=%h hv=%b exp 0 0 0", d_count, d_keys, d_head_valid);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ascending();
    apply_reset();
    push(8'd3, 15'd1); push(8'd1, 15'd2); push(8'd2, 15'd3);
    total++; if (a_keys !== pk(1, 2, 3, 0) || a_count !== 3'd3 || a_head_key !== 8'd1) begin
      bad++; $display("FAIL ascending: got keys=%h cnt=%0d head=%0d exp %h 3 1", a_keys, a_count, a_head_key, pk(1, 2, 3, 0));
    end
  endtask

`ifdef SORTED_QUEUE_DROP_CNT_EN
  task automatic test_drop_count();
    apply_reset();
    push(8'd9, 15'd1); push(8'd7, 15'd2); push(8'd5, 15'd3); push(8'd3, 15'd4);
    total++; if (d_drop !== 16'd0) begin bad++; $display("FAIL drop_cnt_zero: got %0d exp 0", d_drop); end
    push(8'd1, 15'd5); push(8'd8, 15'd6); push(8'd2, 15'd7);
    total++; if (d_drop !== 16'd3) begin bad++; $display("FAIL drop_cnt_three: got %0d exp 3", d_drop); end
    step(1'b0, 8'd0, 15'd0, 1'b0, 1'b1);
    total++; if (d_drop !== 16'd3) begin bad++; $display("FAIL drop_cnt_flush: got %0d exp 3", d_drop); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_equal_keys();
    test_overflow();
    test_push_pop();
    test_back_to_back_full();
    test_empty();
    test_flush_and_async_reset();
    test_ascending();
`ifdef SORTED_QUEUE_DROP_CNT_EN
    test_drop_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
